// File: rtl/mem_access.sv
// Memory stage of the mriscv pipeline: runs load/store transactions on a req/ack
// bus and emits a one-cycle writeback or fault pulse for every accepted op.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_i,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [1:0]  fault
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_MISALGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_func3;
  logic [1:0]       r_off;
  logic [4:0]       r_dest;

  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_be;

  logic             r_wb_valid;
  logic [4:0]       r_wb_dest;
  logic [31:0]      r_wb_data;
  logic [1:0]       r_fault;

  logic             w_mem_op;
  logic             w_illegal;
  logic             w_misaligned;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_lane;
  logic [31:0]      w_load_data;

  assign w_mem_op = is_load | is_store;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_illegal = 1'b0;
    if (is_load && is_store) begin
      w_illegal = 1'b1;
    end else if (is_load) begin
      w_illegal = (func3 == 3'b011) || (func3[2:1] == 2'b11);
    end else if (is_store) begin
      w_illegal = func3[2] || (func3[1:0] == 2'b11);
    end

    w_misaligned = ((func3[1:0] == 2'b01) && result[0]) ||
                   ((func3[1:0] == 2'b10) && (result[1:0] != 2'b00));
  end

  // Stores replicate the datum across lanes; the byte enables pick the lane.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << result[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  assign w_lane = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_data = w_lane;
    case (r_func3)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_data = {24'd0, w_lane[7:0]};
      3'b101:  w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_func3     <= 3'b000;
      r_off       <= 2'b00;
      r_dest      <= 5'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= 5'd0;
      r_wb_data   <= 32'd0;
      r_fault     <= FLT_NONE;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_dest  <= 5'd0;
      r_wb_data  <= 32'd0;
      r_fault    <= FLT_NONE;

      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            if (!w_mem_op) begin
              r_wb_valid <= 1'b1;
              r_wb_dest  <= dest_i;
              r_wb_data  <= result;
            end else if (w_illegal) begin
              r_fault <= FLT_ILLEGAL;
            end else if (w_misaligned) begin
              r_fault <= FLT_MISALGN;
            end else begin
              r_state     <= S_BUS;
              r_cnt       <= '0;
              r_func3     <= func3;
              r_off       <= result[1:0];
              r_dest      <= dest_i;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store;
              r_mem_addr  <= {result[31:2], 2'b00};
              r_mem_wdata <= is_store ? w_wdata : 32'd0;
              r_mem_be    <= is_store ? w_be : 4'b1111;
            end
          end
        end

        S_BUS: begin
          // An ack in the last allowed cycle still counts as a normal completion.
          if (mem_ack || (r_cnt == CNT_LAST)) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'b0000;
            if (mem_ack) begin
              r_wb_valid <= 1'b1;
              r_wb_dest  <= r_mem_we ? 5'd0 : r_dest;
              r_wb_data  <= r_mem_we ? 32'd0 : w_load_data;
            end else begin
              r_fault <= FLT_TIMEOUT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_BUS);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign wb_valid  = r_wb_valid;
  assign wb_dest   = r_wb_dest;
  assign wb_data   = r_wb_data;
  assign fault     = r_fault;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: a vector table drives ops, a scoreboard queue holds the
// expected writeback/fault pulses, and hand sequences cover timeout and reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] result;
  logic [31:0] store_data;
  logic [4:0]  dest_i;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [1:0]  fault;

  mem_access #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .func3      (func3),
    .result     (result),
    .store_data (store_data),
    .dest_i     (dest_i),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_valid   (wb_valid),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic [31:0] rdata;
    logic [1:0]  dly;
    logic        bus;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wbv;
    logic [4:0]  wbd;
    logic [31:0] wbdat;
    logic [1:0]  flt;
  } t_vec;

  typedef struct packed {
    logic        wbv;
    logic [4:0]  wbd;
    logic [31:0] wbdat;
    logic [1:0]  flt;
  } t_exp;

  localparam int NVEC = 21;

  t_vec vecs [NVEC];
  t_exp sb [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses are registered at a rising edge, so the falling edge sees each exactly once.
  always @(negedge clk) begin
    if (wb_valid || (fault != 2'b00)) begin
      check("wb_fault_excl", 32'(wb_valid && (fault != 2'b00)), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {25'd0, wb_valid, wb_dest[4:0] & 5'd0, fault}, 32'd0);
      end else begin
        t_exp e;
        e = sb.pop_front();
        check("wb_valid", 32'(wb_valid), 32'(e.wbv));
        check("fault", 32'(fault), 32'(e.flt));
        if (e.wbv) begin
          check("wb_dest", 32'(wb_dest), 32'(e.wbd));
          check("wb_data", wb_data, e.wbdat);
        end
      end
    end
  end

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] sd, input logic [4:0] dest);
    valid_i    = 1'b1;
    is_load    = ld;
    is_store   = st;
    func3      = f3;
    result     = res;
    store_data = sd;
    dest_i     = dest;
  endtask

  task automatic idle_inputs();
    valid_i  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  task automatic apply_vec(input int idx, input t_vec v);
    t_exp e;
    e.wbv   = v.wbv;
    e.wbd   = v.wbd;
    e.wbdat = v.wbdat;
    e.flt   = v.flt;
    sb.push_back(e);
    drive_op(v.ld, v.st, v.f3, v.res, v.sd, v.dest);
    tick();
    idle_inputs();
    if (v.bus) begin
      check($sformatf("v%0d_req", idx), 32'(mem_req), 32'd1);
      check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
      check($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.st));
      check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
      check($sformatf("v%0d_be", idx), 32'(mem_be), 32'(v.be));
      if (v.st) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
      for (int k = 0; k < int'(v.dly); k++) begin
        tick();
        check($sformatf("v%0d_req_held", idx), 32'(mem_req), 32'd1);
        check($sformatf("v%0d_addr_held", idx), mem_addr, v.addr);
      end
      mem_rdata = v.rdata;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check($sformatf("v%0d_req_drop", idx), 32'(mem_req), 32'd0);
      check($sformatf("v%0d_busy_drop", idx), 32'(busy), 32'd0);
    end else begin
      check($sformatf("v%0d_no_req", idx), 32'(mem_req), 32'd0);
      check($sformatf("v%0d_no_busy", idx), 32'(busy), 32'd0);
    end
  endtask

  initial begin
    t_exp e;
    int   cnt;

    //           ld    st    f3      res           sd            dest   rdata         dly   bus   addr        be       wdata         wbv   wbd    wbdat         flt
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'd40,       32'd0,        5'd10, 32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b1, 5'd10, 32'd40,       2'b00};
    vecs[1]  = '{1'b0, 1'b0, 3'b000, 32'hDEADBEEF, 32'd0,        5'd31, 32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b1, 5'd31, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h103,      32'd0,        5'd5,  32'h80AA5511, 2'd2, 1'b1, 32'h100,    4'hF,    32'd0,        1'b1, 5'd5,  32'hFFFFFF80, 2'b00};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h103,      32'd0,        5'd6,  32'h80AA5511, 2'd2, 1'b1, 32'h100,    4'hF,    32'd0,        1'b1, 5'd6,  32'h00000080, 2'b00};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102,      32'd0,        5'd7,  32'h80AA5511, 2'd1, 1'b1, 32'h100,    4'hF,    32'd0,        1'b1, 5'd7,  32'hFFFF80AA, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h100,      32'd0,        5'd8,  32'h80AA9511, 2'd0, 1'b1, 32'h100,    4'hF,    32'd0,        1'b1, 5'd8,  32'h00009511, 2'b00};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h204,      32'd0,        5'd9,  32'h12345678, 2'd3, 1'b1, 32'h204,    4'hF,    32'd0,        1'b1, 5'd9,  32'h12345678, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 32'h101,      32'd0,        5'd11, 32'h80AA5511, 2'd1, 1'b1, 32'h100,    4'hF,    32'd0,        1'b1, 5'd11, 32'h00000055, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h202,      32'h1234ABCD, 5'd12, 32'd0,        2'd0, 1'b1, 32'h200,    4'b1100, 32'hABCDABCD, 1'b1, 5'd0,  32'd0,        2'b00};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h301,      32'h000000EE, 5'd13, 32'd0,        2'd1, 1'b1, 32'h300,    4'b0010, 32'hEEEEEEEE, 1'b1, 5'd0,  32'd0,        2'b00};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h400,      32'hCAFEF00D, 5'd14, 32'd0,        2'd2, 1'b1, 32'h400,    4'b1111, 32'hCAFEF00D, 1'b1, 5'd0,  32'd0,        2'b00};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h500,      32'h1234ABCD, 5'd15, 32'd0,        2'd0, 1'b1, 32'h500,    4'b0011, 32'hABCDABCD, 1'b1, 5'd0,  32'd0,        2'b00};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h6,        32'd0,        5'd1,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b01};
    vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h0,        32'd0,        5'd1,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b11};
    vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h0,        32'h55,       5'd1,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b11};
    vecs[15] = '{1'b1, 1'b0, 3'b001, 32'h101,      32'd0,        5'd2,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b01};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 32'h7,        32'd0,        5'd3,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b11};
    vecs[17] = '{1'b1, 1'b0, 3'b110, 32'h3,        32'd0,        5'd4,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b11};
    vecs[18] = '{1'b1, 1'b0, 3'b010, 32'h10,       32'd0,        5'd0,  32'h55AA55AA, 2'd1, 1'b1, 32'h10,     4'hF,    32'd0,        1'b1, 5'd0,  32'h55AA55AA, 2'b00};
    vecs[19] = '{1'b0, 1'b1, 3'b000, 32'h3,        32'hFFFFFF7F, 5'd5,  32'd0,        2'd0, 1'b1, 32'h0,      4'b1000, 32'h7F7F7F7F, 1'b1, 5'd0,  32'd0,        2'b00};
    vecs[20] = '{1'b0, 1'b1, 3'b011, 32'h0,        32'h55,       5'd6,  32'd0,        2'd0, 1'b0, 32'd0,      4'h0,    32'd0,        1'b0, 5'd0,  32'd0,        2'b11};

    reset      = 1'b1;
    valid_i    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    func3      = 3'b000;
    result     = 32'd0;
    store_data = 32'd0;
    dest_i     = 5'd0;
    mem_rdata  = 32'd0;
    mem_ack    = 1'b0;
    repeat (3) tick();

    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) apply_vec(i, vecs[i]);

    // Back-to-back ALU ops, one per cycle, with a stray ack in IDLE that must be ignored.
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = '{1'b1, 5'(20 + i), 32'(32'h1000 + i), 2'b00};
      sb.push_back(e);
      drive_op(1'b0, 1'b0, 3'b010, 32'(32'h1000 + i), 32'd0, 5'(20 + i));
      tick();
      check("b2b_no_req", 32'(mem_req), 32'd0);
      check("b2b_wb_valid", 32'(wb_valid), 32'd1);
    end
    idle_inputs();
    mem_ack = 1'b0;
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // Timeout: no ack ever; mem_req must stay up for exactly 16 cycles.
    e = '{1'b0, 5'd0, 32'd0, 2'b10};
    sb.push_back(e);
    drive_op(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd3);
    tick();
    idle_inputs();
    check("to_addr", mem_addr, 32'h40);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", 32'(cnt), 32'd16);
    check("to_busy", 32'(busy), 32'd0);
    check("to_fault", 32'(fault), 32'(2'b10));
    tick();

    // Ack arriving in the 16th request cycle completes normally.
    e = '{1'b1, 5'd3, 32'hA5A5A5A5, 2'b00};
    sb.push_back(e);
    drive_op(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd3);
    tick();
    idle_inputs();
    repeat (15) tick();
    check("to16_req_still", 32'(mem_req), 32'd1);
    mem_rdata = 32'hA5A5A5A5;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("to16_req_drop", 32'(mem_req), 32'd0);
    check("to16_wb_valid", 32'(wb_valid), 32'd1);
    check("to16_no_fault", 32'(fault), 32'd0);
    tick();

    // Reset mid-transaction: mem_req drops at the reset edge and nothing follows.
    drive_op(1'b0, 1'b1, 3'b010, 32'h80, 32'h11223344, 5'd7);
    tick();
    idle_inputs();
    tick();
    check("mid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_req", 32'(mem_req), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_we", 32'(mem_we), 32'd0);
    check("mid_addr", mem_addr, 32'd0);
    check("mid_wdata", mem_wdata, 32'd0);
    check("mid_be", 32'(mem_be), 32'd0);
    check("mid_wb_valid", 32'(wb_valid), 32'd0);
    check("mid_fault", 32'(fault), 32'd0);
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    check("mid_after_req", 32'(mem_req), 32'd0);
    check("mid_after_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
